// File: rtl/sf_camera_seq_controller_pkg.sv
// Shared definitions for the camera sequencing controller: control-word bit
// positions, FSM state encoding and small width/decode helpers.
// No logic of its own; imported by the controller and its sub-module.
package sf_camera_seq_controller_pkg;

  // Bit positions inside the 32-bit control word from the register file.
  localparam int CTRL_ENABLE       = 0;
  localparam int CTRL_CONTINUOUS   = 1;
  localparam int CTRL_AUTO_FLASH   = 2;
  localparam int CTRL_MANUAL_FLASH = 3;
  localparam int CTRL_CAM_RESET    = 4;
  localparam int CTRL_START        = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RESET   = 3'd1,
    WAKE    = 3'd2,
    ARM     = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5
  } cam_state_t;

  // Width of a buffer index; a single buffer still needs a 1-bit port.
  function automatic int buf_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Camera is considered ready once the wake-up sequence has completed.
  function automatic logic cam_ready(input cam_state_t s);
    return (s == ARM) || (s == CAPTURE) || (s == DONE);
  endfunction

  // Camera reset line is asserted until the wake-up phase begins.
  function automatic logic cam_in_reset(input cam_state_t s);
    return (s == IDLE) || (s == RESET);
  endfunction

endpackage

// File: rtl/sf_camera_seq_controller_clk_div.sv
// Purpose: divides clk down to the camera input clock (clk / (2*CLK_DIV)).
// Latency: output is a register; first rising edge CLK_DIV cycles after i_en rises.
// Backpressure: none; i_en low clears the counter and parks the clock low.
// Ports: clk/rst (sync, active-high), i_en run enable, o_clk divided clock.
module sf_camera_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_clk
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !i_en) begin
      cnt   <= '0;
      o_clk <= 1'b0;
    end else if (cnt == TERM) begin
      cnt   <= '0;
      o_clk <= ~o_clk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sf_camera_seq_controller.sv
// Purpose: sequences camera reset/wake-up, arms single-shot or continuous
//          captures, rotates frame buffers and drives the flash LED.
// Latency: every output is registered and reflects the next state, so it
//          changes one cycle after the input or state change that causes it.
// Backpressure: none; i_captured and control edges are acted on the cycle they
//          arrive, and events outside the state that uses them are dropped.
// Ports: clk/rst (sync, active-high); i_control control word; i_captured frame
//        complete pulse; i_flash_strobe camera strobe; o_cam_rst, o_cam_in_clk,
//        o_flash camera-side drives; o_status/o_busy status; o_enable_dma,
//        o_enable_reader capture enables; o_buf_sel target buffer;
//        o_frame_count completed frames.
module sf_camera_seq_controller
  import sf_camera_seq_controller_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int RST_CYCLES   = 16,
  parameter int WAKE_CYCLES  = 32,
  parameter int FLASH_CYCLES = 8,
  parameter int NUM_BUFFERS  = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [31:0]                       i_control,
  input  logic                              i_captured,
  input  logic                              i_flash_strobe,
  output logic                              o_cam_rst,
  output logic                              o_cam_in_clk,
  output logic                              o_flash,
  output logic                              o_status,
  output logic                              o_busy,
  output logic                              o_enable_dma,
  output logic                              o_enable_reader,
  output logic [buf_width(NUM_BUFFERS)-1:0] o_buf_sel,
  output logic [15:0]                       o_frame_count
);

  localparam int BUF_W   = buf_width(NUM_BUFFERS);
  localparam int SEQ_MAX = (RST_CYCLES > WAKE_CYCLES) ? RST_CYCLES : WAKE_CYCLES;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam int FL_W    = $clog2(FLASH_CYCLES + 1);

  localparam logic [SEQ_W-1:0] RST_LAST  = SEQ_W'(RST_CYCLES - 1);
  localparam logic [SEQ_W-1:0] WAKE_LAST = SEQ_W'(WAKE_CYCLES - 1);
  localparam logic [FL_W-1:0]  FL_LOAD   = FL_W'(FLASH_CYCLES);
  localparam logic [BUF_W-1:0] BUF_LAST  = BUF_W'(NUM_BUFFERS - 1);

  // Control word decode
  logic enable, continuous, auto_flash, manual_flash, cam_reset, start;
  logic unused_control;

  assign enable         = i_control[CTRL_ENABLE];
  assign continuous     = i_control[CTRL_CONTINUOUS];
  assign auto_flash     = i_control[CTRL_AUTO_FLASH];
  assign manual_flash   = i_control[CTRL_MANUAL_FLASH];
  assign cam_reset      = i_control[CTRL_CAM_RESET];
  assign start          = i_control[CTRL_START];
  assign unused_control = ^i_control[31:6];

  // Edge detection on the level-sensitive control bits and the strobe
  logic cam_reset_q, start_q, strobe_q;
  logic cam_reset_rise, start_rise, strobe_rise;

  assign cam_reset_rise = cam_reset & ~cam_reset_q;
  assign start_rise     = start & ~start_q;
  assign strobe_rise    = i_flash_strobe & ~strobe_q;

  cam_state_t       state, nxt_state;
  logic [SEQ_W-1:0] seq_cnt, nxt_seq_cnt;
  logic [FL_W-1:0]  flash_cnt, nxt_flash_cnt;
  logic             frame_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state     = state;
    frame_done    = 1'b0;
    nxt_seq_cnt   = '0;
    nxt_flash_cnt = '0;

    // Overrides first: disable beats a camera-reset request, which beats a
    // frame completion arriving in the same cycle.
    if (!enable) begin
      nxt_state = IDLE;
    end else if (cam_reset_rise && state != IDLE && state != RESET) begin
      nxt_state = RESET;
    end else begin
      case (state)
        IDLE:    nxt_state = RESET;
        RESET:   if (seq_cnt == RST_LAST)  nxt_state = WAKE;
        WAKE:    if (seq_cnt == WAKE_LAST) nxt_state = ARM;
        ARM:     if (continuous || start_rise) nxt_state = CAPTURE;
        CAPTURE: begin
          if (i_captured) begin
            nxt_state  = DONE;
            frame_done = 1'b1;
          end
        end
        DONE:    nxt_state = continuous ? CAPTURE : ARM;
        default: nxt_state = IDLE;
      endcase
    end

    // Dwell counter restarts on every state change so each timed phase
    // lasts exactly its programmed length regardless of how it was entered.
    if (nxt_state == state && (state == RESET || state == WAKE)) begin
      nxt_seq_cnt = seq_cnt + 1'b1;
    end

    // Auto-flash pulse only lives inside CAPTURE; leaving CAPTURE clears it.
    if (nxt_state == CAPTURE) begin
      if (state == CAPTURE && auto_flash && strobe_rise) begin
        nxt_flash_cnt = FL_LOAD;
      end else if (flash_cnt != '0) begin
        nxt_flash_cnt = flash_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_cnt         <= '0;
      flash_cnt       <= '0;
      cam_reset_q     <= 1'b0;
      start_q         <= 1'b0;
      strobe_q        <= 1'b0;
      o_cam_rst       <= 1'b1;
      o_flash         <= 1'b0;
      o_status        <= 1'b0;
      o_busy          <= 1'b0;
      o_enable_dma    <= 1'b0;
      o_enable_reader <= 1'b0;
      o_buf_sel       <= '0;
      o_frame_count   <= '0;
    end else begin
      seq_cnt         <= nxt_seq_cnt;
      flash_cnt       <= nxt_flash_cnt;
      cam_reset_q     <= cam_reset;
      start_q         <= start;
      strobe_q        <= i_flash_strobe;
      o_cam_rst       <= cam_in_reset(nxt_state);
      o_flash         <= manual_flash | (nxt_flash_cnt != '0);
      o_status        <= cam_ready(nxt_state);
      o_busy          <= (nxt_state == CAPTURE);
      o_enable_dma    <= (nxt_state == CAPTURE);
      o_enable_reader <= (nxt_state == CAPTURE);
      if (frame_done) begin
        o_frame_count <= o_frame_count + 16'd1;
        o_buf_sel     <= (o_buf_sel == BUF_LAST) ? '0 : o_buf_sel + 1'b1;
      end
    end
  end

  sf_camera_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk   (clk),
    .rst   (rst),
    .i_en  (enable),
    .o_clk (o_cam_in_clk)
  );

endmodule

// File: tb/tb_sf_camera_seq_controller.sv
// Directed bench for the camera sequencing controller with default parameters.
// Stimulus pushes cycle-stamped expected output snapshots into a queue; a
// monitor on the falling clock edge pops and compares them.
module tb_sf_camera_seq_controller;
  import sf_camera_seq_controller_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] control = '0;
  logic        captured = 1'b0;
  logic        strobe = 1'b0;
  logic        o_cam_rst, o_cam_in_clk, o_flash, o_status, o_busy;
  logic        o_enable_dma, o_enable_reader;
  logic [0:0]  o_buf_sel;
  logic [15:0] o_frame_count;

  always #5 clk = ~clk;

  sf_camera_seq_controller dut (
    .clk             (clk),
    .rst             (rst),
    .i_control       (control),
    .i_captured      (captured),
    .i_flash_strobe  (strobe),
    .o_cam_rst       (o_cam_rst),
    .o_cam_in_clk    (o_cam_in_clk),
    .o_flash         (o_flash),
    .o_status        (o_status),
    .o_busy          (o_busy),
    .o_enable_dma    (o_enable_dma),
    .o_enable_reader (o_enable_reader),
    .o_buf_sel       (o_buf_sel),
    .o_frame_count   (o_frame_count)
  );

  // Flag vector order: {cam_rst, cam_in_clk, flash, status, busy, dma, reader}
  localparam logic [6:0] F_RST  = 7'b1000000;
  localparam logic [6:0] F_WAKE = 7'b0000000;
  localparam logic [6:0] F_ARM  = 7'b0001000;
  localparam logic [6:0] F_CAP  = 7'b0001111;
  localparam logic [6:0] F_DONE = 7'b0001000;
  localparam logic [6:0] F_FL   = 7'b0010000;
  localparam logic [6:0] F_CK   = 7'b0100000;
  localparam logic [6:0] M_ALL  = 7'b1111111;
  localparam logic [6:0] M_NCK  = 7'b1011111;
  localparam logic [6:0] M_RC   = 7'b1100000;

  localparam logic [31:0] C_EN   = 32'h1 << CTRL_ENABLE;
  localparam logic [31:0] C_CONT = 32'h1 << CTRL_CONTINUOUS;
  localparam logic [31:0] C_AUTO = 32'h1 << CTRL_AUTO_FLASH;
  localparam logic [31:0] C_MAN  = 32'h1 << CTRL_MANUAL_FLASH;
  localparam logic [31:0] C_CR   = 32'h1 << CTRL_CAM_RESET;
  localparam logic [31:0] C_ST   = 32'h1 << CTRL_START;

  typedef struct {
    int             cyc;
    logic [8*12-1:0] name;
    logic [6:0]     flags;
    logic [6:0]     mask;
    logic [15:0]    cnt;
    logic [0:0]     bsel;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int dly, input logic [8*12-1:0] name,
                           input logic [6:0] flags, input logic [6:0] mask,
                           input int cnt, input int bsel);
    exp_t x;
    x.cyc   = cyc + dly;
    x.name  = name;
    x.flags = flags;
    x.mask  = mask;
    x.cnt   = 16'(cnt);
    x.bsel  = 1'(bsel);
    sb.push_back(x);
  endtask

  // Monitor: compare every snapshot due in the current cycle.
  always @(negedge clk) begin
    logic [6:0] act;
    act = {o_cam_rst, o_cam_in_clk, o_flash, o_status, o_busy,
           o_enable_dma, o_enable_reader};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc || ((act ^ e.flags) & e.mask) != 7'b0 ||
          o_frame_count != e.cnt || o_buf_sel != e.bsel) begin
        errors++;
        $display("FAIL %0s cyc=%0d due=%0d: got flags=%b cnt=%0d buf=%0d, want flags=%b mask=%b cnt=%0d buf=%0d",
                 e.name, cyc, e.cyc, act, o_frame_count, o_buf_sel,
                 e.flags, e.mask, e.cnt, e.bsel);
      end
    end
  end

  // Reset, then enable: RESET lasts 16 cycles, WAKE 32, camera clock period 4.
  task automatic bring_up();
    logic [8:1] ck_pat;
    ck_pat   = 8'b0110_0110;
    rst      = 1'b1;
    control  = '0;
    captured = 1'b0;
    strobe   = 1'b0;
    tick();
    tick();
    expect_at(0, "rst_state", F_RST, M_ALL, 0, 0);
    tick();
    rst     = 1'b0;
    control = C_EN;
    for (int k = 1; k <= 8; k++)
      expect_at(k, "cam_clk", ck_pat[k] ? (F_RST | F_CK) : F_RST, M_RC, 0, 0);
    expect_at(16, "reset_end", F_RST,  M_NCK, 0, 0);
    expect_at(17, "wake_start", F_WAKE, M_NCK, 0, 0);
    expect_at(48, "wake_end", F_WAKE, M_NCK, 0, 0);
    expect_at(49, "arm_reached", F_ARM, M_NCK, 0, 0);
    repeat (50) tick();
  endtask

  // One single-shot frame from ARM, back to ARM.
  task automatic frame_from_arm(input int c0, input int b0);
    control = C_EN | C_ST;
    expect_at(1, "fa_cap", F_CAP, M_NCK, c0, b0);
    tick();
    control  = C_EN;
    tick();
    captured = 1'b1;
    expect_at(1, "fa_done", F_DONE, M_NCK, c0 + 1, (b0 + 1) % 2);
    expect_at(2, "fa_arm", F_ARM, M_NCK, c0 + 1, (b0 + 1) % 2);
    tick();
    captured = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", sb.size());
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- single shot, START discarded outside ARM, stray i_captured ----
    bring_up();
    control = C_EN | C_ST;
    expect_at(1, "ss_cap", F_CAP, M_NCK, 0, 0);
    tick();
    control = C_EN;
    expect_at(2, "ss_busy", F_CAP, M_NCK, 0, 0);
    tick();
    tick();
    captured = 1'b1;
    expect_at(1, "ss_done", F_DONE, M_NCK, 1, 1);
    tick();
    captured = 1'b0;
    control  = C_EN | C_ST;
    expect_at(1, "ss_arm", F_ARM, M_NCK, 1, 1);
    expect_at(2, "ss_nostart", F_ARM, M_NCK, 1, 1);
    tick();
    tick();
    control  = C_EN;
    captured = 1'b1;
    expect_at(1, "cap_ignore", F_ARM, M_NCK, 1, 1);
    tick();
    captured = 1'b0;
    tick();
    control = C_EN | C_ST;
    expect_at(1, "ss2_cap", F_CAP, M_NCK, 1, 1);
    tick();
    control = C_EN;
    tick();
    captured = 1'b1;
    expect_at(1, "ss2_done", F_DONE, M_NCK, 2, 0);
    expect_at(2, "ss2_arm", F_ARM, M_NCK, 2, 0);
    tick();
    captured = 1'b0;
    tick();
    tick();

    // ---- continuous: three frames, then clear CONTINUOUS mid-frame ----
    bring_up();
    control = C_EN | C_CONT;
    expect_at(1, "ct_cap", F_CAP, M_NCK, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      captured = 1'b1;
      expect_at(1, "ct_done", F_DONE, M_NCK, i + 1, (i + 1) % 2);
      expect_at(2, "ct_recap", F_CAP, M_NCK, i + 1, (i + 1) % 2);
      tick();
      captured = 1'b0;
      tick();
    end
    control = C_EN;
    expect_at(1, "ct_stay", F_CAP, M_NCK, 3, 1);
    tick();
    tick();
    captured = 1'b1;
    expect_at(1, "ct_last", F_DONE, M_NCK, 4, 0);
    expect_at(2, "ct_arm", F_ARM, M_NCK, 4, 0);
    tick();
    captured = 1'b0;
    tick();
    tick();

    // ---- auto flash, re-strobe, truncation, manual flash ----
    bring_up();
    control = C_EN | C_CONT | C_AUTO;
    expect_at(1, "af_cap", F_CAP, M_NCK, 0, 0);
    tick();
    tick();
    strobe = 1'b1;
    for (int k = 1; k <= 14; k++)
      expect_at(k, "af_pulse", (k <= 13) ? (F_CAP | F_FL) : F_CAP, M_NCK, 0, 0);
    tick();
    strobe = 1'b0;
    repeat (4) tick();
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    repeat (9) tick();
    strobe = 1'b1;
    for (int k = 1; k <= 3; k++)
      expect_at(k, "tr_pulse", F_CAP | F_FL, M_NCK, 0, 0);
    tick();
    strobe = 1'b0;
    tick();
    tick();
    captured = 1'b1;
    expect_at(1, "tr_done", F_DONE, M_NCK, 1, 1);
    expect_at(2, "tr_recap", F_CAP, M_NCK, 1, 1);
    tick();
    captured = 1'b0;
    tick();
    control  = C_EN | C_MAN;
    captured = 1'b1;
    expect_at(1, "mf_done", F_DONE | F_FL, M_NCK, 2, 0);
    expect_at(2, "mf_arm", F_ARM | F_FL, M_NCK, 2, 0);
    tick();
    captured = 1'b0;
    tick();
    control = C_MAN;
    expect_at(1, "mf_idle", F_RST | F_FL, M_ALL, 2, 0);
    tick();
    tick();

    // ---- ENABLE falling together with i_captured ----
    bring_up();
    frame_from_arm(0, 0);
    control = C_EN | C_ST;
    expect_at(1, "pe_cap", F_CAP, M_NCK, 1, 1);
    tick();
    control = C_EN;
    tick();
    control  = '0;
    captured = 1'b1;
    expect_at(1, "pe_idle", F_RST, M_ALL, 1, 1);
    expect_at(2, "pe_idle2", F_RST, M_ALL, 1, 1);
    tick();
    captured = 1'b0;
    tick();
    tick();

    // ---- CAM_RESET edge together with i_captured ----
    bring_up();
    frame_from_arm(0, 0);
    control = C_EN | C_ST;
    tick();
    control = C_EN;
    tick();
    control  = C_EN | C_CR;
    captured = 1'b1;
    expect_at(1, "pc_reset", F_RST, M_NCK, 1, 1);
    expect_at(16, "pc_rst_end", F_RST, M_NCK, 1, 1);
    expect_at(17, "pc_wake", F_WAKE, M_NCK, 1, 1);
    tick();
    captured = 1'b0;
    control  = C_EN;
    repeat (17) tick();

    // ---- synchronous reset applied during CAPTURE ----
    bring_up();
    frame_from_arm(0, 0);
    control = C_EN | C_ST;
    tick();
    control = C_EN;
    tick();
    rst = 1'b1;
    expect_at(1, "rs_reset", F_RST, M_ALL, 0, 0);
    expect_at(2, "rs_hold", F_RST, M_ALL, 0, 0);
    tick();
    tick();
    tick();
    rst     = 1'b0;
    control = '0;
    repeat (3) tick();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected snapshots never compared, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sf_camera_seq_controller.md
Name: sf_camera_seq_controller

Overview:
- Parametrised camera sequencing controller for the SparkFun camera slave.
- Generates the camera input clock with an internal divider, so no clock-gen primitive is needed.
- Sequences camera reset and wake-up, then arms single-shot or continuous frame captures.
- Rotates DMA/reader enables across NUM_BUFFERS frame buffers and drives flash in manual or strobe-triggered mode.
- Sits between the wishbone register file (i_control, i_captured) and the DMA/reader cores.

Parameters:
- CLK_DIV, 2: half-period of o_cam_in_clk in clk cycles (>=1); o_cam_in_clk = clk/(2*CLK_DIV).
- RST_CYCLES, 16: number of cycles o_cam_rst is held in the RESET state (>=1).
- WAKE_CYCLES, 32: number of cycles from reset release to ARM (>=1).
- FLASH_CYCLES, 8: length in clk cycles of the auto-flash pulse (>=1).
- NUM_BUFFERS, 2: number of frame buffers rotated (>=1).
- BUF_W, derived: localparam max(1, clog2(NUM_BUFFERS)).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_control  in  32  control word:
  - [0] ENABLE
  - [1] CONTINUOUS
  - [2] AUTO_FLASH
  - [3] MANUAL_FLASH
  - [4] CAM_RESET (acts on rising edge)
  - [5] START (acts on rising edge)
  - all other bits are ignored
- i_captured  in  1  one-cycle pulse: the current frame is fully captured
- i_flash_strobe  in  1  camera flash strobe, synchronous to clk
- o_cam_rst  out  1  camera reset, active-high
- o_cam_in_clk  out  1  divided camera input clock
- o_flash  out  1  flash LED drive
- o_status  out  1  camera ready (state is ARM, CAPTURE or DONE)
- o_busy  out  1  high while in CAPTURE
- o_enable_dma  out  1  DMA enable
- o_enable_reader  out  1  pixel reader enable
- o_buf_sel  out  BUF_W  frame buffer index currently targeted
- o_frame_count  out  16  number of completed frames

Behaviour:
- Reset values:
  - o_cam_rst=1
  - all other outputs 0, including o_cam_in_clk and o_buf_sel
  - state=IDLE
  - counters and edge-detect registers cleared
- Outputs are registered and change one cycle after the causing input or state change.
- Clock divider:
  - Runs only while ENABLE=1.
  - Counts 0..CLK_DIV-1 and toggles o_cam_in_clk at terminal count.
  - While ENABLE=0: counter cleared, clock held low.
- FSM states and transitions:
  - IDLE: o_cam_rst=1. ENABLE=1 moves to RESET.
  - RESET: o_cam_rst=1. After exactly RST_CYCLES cycles in RESET, moves to WAKE.
  - WAKE: o_cam_rst=0 from the first WAKE cycle. After exactly WAKE_CYCLES cycles, moves to ARM.
  - ARM: o_status=1. CONTINUOUS=1, or a START rising edge, moves to CAPTURE.
  - CAPTURE:
    - o_enable_dma=o_enable_reader=1, o_busy=1 from the first CAPTURE cycle.
    - On i_captured: o_frame_count++ (wraps 0xFFFF to 0); o_buf_sel++ (wraps NUM_BUFFERS-1 to 0); move to DONE.
  - DONE: enables low, exactly one cycle. Then go to CAPTURE if CONTINUOUS=1, else ARM.
- Overrides, with priority ENABLE=0 > CAM_RESET rising edge > i_captured:
  - ENABLE=0 in any state: go to IDLE next cycle; enables and flash drop; frame count not incremented.
  - CAM_RESET rising edge in WAKE, ARM, CAPTURE or DONE: go to RESET; enables drop; o_buf_sel and o_frame_count unchanged.
- i_captured outside CAPTURE is ignored.
- START edges outside ARM are discarded, not queued.
- Flash:
  - o_flash = MANUAL_FLASH OR auto_pulse.
  - auto_pulse starts on an i_flash_strobe rising edge while in CAPTURE with AUTO_FLASH=1, and lasts FLASH_CYCLES cycles.
  - A new edge during the pulse restarts the count.
  - The pulse is truncated immediately on leaving CAPTURE.
- Clearing CONTINUOUS mid-CAPTURE finishes the current frame, then returns to ARM.

Decomposition:
- Shared include holds:
  - control bit indices (CTRL_ENABLE=0 … CTRL_START=5)
  - FSM state encodings: IDLE, RESET, WAKE, ARM, CAPTURE, DONE
- Sub-module sf_camera_clk_div (parameter CLK_DIV; ports clk, rst, i_en, o_clk) implements the divider.
- All other logic is inline.

Test Plan:
- Power-up with defaults: rst, then ENABLE=1.
  - o_cam_rst stays 1 through IDLE and RESET, then falls.
  - o_status rises 32 cycles after o_cam_rst falls.
  - o_cam_in_clk period is 4 clk cycles.
- Single shot: in ARM, pulse START, then pulse i_captured.
  - Enables high until one cycle after the i_captured pulse.
  - o_frame_count=1, o_buf_sel=1, FSM returns to ARM.
  - A second START leaves o_buf_sel=0 (wrap with NUM_BUFFERS=2).
- Continuous: CONTINUOUS=1 and 3 i_captured pulses.
  - Enables low for exactly 1 cycle (DONE) between frames.
  - o_frame_count=3, o_buf_sel sequence 0,1,0,1.
- Auto flash: AUTO_FLASH=1 in CAPTURE, strobe edge.
  - o_flash high 8 cycles.
  - A re-strobe at cycle 5 extends the pulse to 13 cycles total.
  - MANUAL_FLASH=1 forces o_flash high in every state.
- Priority: i_captured coincident with ENABLE falling.
  - FSM goes to IDLE, o_frame_count unchanged, enables 0 next cycle, o_cam_rst=1.
  - Same test with a CAM_RESET edge instead: FSM goes to RESET, count unchanged.
- Mid-reset re-sync: apply rst during CAPTURE.
  - All outputs return to reset values next cycle.
  - o_frame_count=0.
